// File: rtl/sd_lane_deserializer.sv
// Multi-lane serial frame receiver: start bit, framesize data bits per lane, optional CRC16, end bit.
// Optional per-lane CRC16 check is built when macro SD_DESER_CRC16_EN is defined.
module sd_lane_deserializer #(
  parameter int BITS         = 32,
  parameter int BITS_COUNTER = 8,
  parameter int LANES        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    wide,
  input  logic [BITS_COUNTER-1:0] framesize,
  input  logic [LANES-1:0]        in,
  output logic [BITS-1:0]         out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    crc_err
);

`ifdef SD_DESER_CRC16_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_START = 3'd1, DATA = 3'd2, CRC = 3'd3, END = 3'd4, DONE = 3'd5
  } state_t;
  localparam state_t AFTER_DATA = CRC;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_START = 3'd1, DATA = 3'd2, END = 3'd3, DONE = 3'd4
  } state_t;
  localparam state_t AFTER_DATA = END;
`endif

  state_t                  state;
  logic                    wide_r;
  logic [BITS_COUNTER-1:0] fs_r;
  logic [BITS_COUNTER-1:0] counter;
  logic [BITS_COUNTER-1:0] counter_next;
  logic [LANES-1:0]        active;
  logic [BITS-1:0]         shifted;

  // Active-lane mask, next counter value and next shift-register contents
  always_comb begin
    active       = wide_r ? {LANES{1'b1}} : LANES'(1);
    counter_next = counter + BITS_COUNTER'(1);
    if (wide_r) begin
      shifted = {out[BITS-LANES-1:0], in};
    end else begin
      shifted = {out[BITS-2:0], in[0]};
    end
  end

`ifdef SD_DESER_CRC16_EN
  logic [15:0] crc [LANES];
  logic [3:0]  crc_cnt;
  logic        crc_mis;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Any active lane whose received CRC bit disagrees with its computed MSB
  always_comb begin
    crc_mis = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (active[l] && (in[l] != crc[l][15])) begin
        crc_mis = 1'b1;
      end else begin
        crc_mis = crc_mis;
      end
    end
  end

  // Per-lane CRC accumulation over data, then MSB-first comparison against the received CRC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) crc[l] <= 16'h0000;
      crc_cnt <= 4'd0;
      crc_err <= 1'b0;
    end else if (state == IDLE && start) begin
      for (int l = 0; l < LANES; l++) crc[l] <= 16'h0000;
      crc_cnt <= 4'd0;
      crc_err <= 1'b0;
    end else if (enable && state == DATA) begin
      for (int l = 0; l < LANES; l++) crc[l] <= crc16_step(crc[l], in[l]);
    end else if (enable && state == CRC) begin
      for (int l = 0; l < LANES; l++) crc[l] <= {crc[l][14:0], 1'b0};
      crc_cnt <= crc_cnt + 4'd1;
      if (crc_mis) crc_err <= 1'b1;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  // Frame sequencer with registered out/out_valid/busy/frame_err
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wide_r    <= 1'b0;
      fs_r      <= '0;
      counter   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wide_r    <= wide;
            fs_r      <= framesize;
            counter   <= '0;
            out       <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (enable && ((in & active) == '0)) begin
            state <= (fs_r == '0) ? AFTER_DATA : DATA;
          end
        end
        DATA: begin
          if (enable) begin
            out     <= shifted;
            counter <= counter_next;
            if (counter_next == fs_r) state <= AFTER_DATA;
          end
        end
`ifdef SD_DESER_CRC16_EN
        CRC: begin
          if (enable && crc_cnt == 4'd15) state <= END;
        end
`endif
        END: begin
          if (enable) begin
            frame_err <= ((in & active) != active);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Handshake deliberately ignores enable
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
